// File: rtl/alu_mc_legv8_pkg.sv
// Shared ALU definitions: FS op codes, FS bit positions, FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_mc_legv8_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_LSL  = 3'b100;
    localparam logic [2:0] OP_LSR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_UDIV = 3'b111;

    localparam int FS_INV_B  = 0;
    localparam int FS_INV_A  = 1;
    localparam int FS_OP_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [2:0] fs_op(input logic [4:0] fs);
        return fs[FS_OP_LSB +: 3];
    endfunction

endpackage

// File: rtl/alu_mc_legv8_if.sv
// Operand/result handshake bundle for the multi-cycle ALU.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry stall in each direction.
interface alu_mc_legv8_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       FS;
    logic             C0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic [3:0]       status;

    modport master (
        output in_valid, A, B, FS, C0, out_ready,
        input  in_ready, out_valid, F, status
    );

    modport slave (
        input  in_valid, A, B, FS, C0, out_ready,
        output in_ready, out_valid, F, status
    );
endinterface

// File: rtl/alu_mc_legv8_iter_unit.sv
// Iterative engine: shift-add unsigned MUL and restoring UDIV, one bit per cycle.
// Latency: WIDTH cycles after start; done flags the final iteration cycle.
// Backpressure: none; the owner must not restart while busy.
module alu_mc_legv8_iter_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result
);
    localparam int SHW = $clog2(WIDTH);

    // acc: product / remainder; x: multiplicand / quotient-dividend; y: multiplier / divisor
    logic             busy_q;
    logic             is_div_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q, x_q, y_q;
    logic [WIDTH-1:0] acc_n, x_n, y_n;
    logic [WIDTH:0]   rem_sh, diff;

    always_comb begin
        acc_n  = acc_q;
        x_n    = x_q;
        y_n    = y_q;
        rem_sh = {acc_q, x_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, y_q};
        if (is_div_q) begin
            // diff MSB is the borrow: set means the trial subtraction is rejected
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                x_n   = {x_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[WIDTH-1:0];
                x_n   = {x_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = acc_q + (y_q[0] ? x_q : '0);
            x_n   = x_q << 1;
            y_n   = y_q >> 1;
        end
    end

    assign div_by_zero = is_div && (b == '0);
    assign busy        = busy_q;
    assign done        = busy_q && (cnt_q == SHW'(WIDTH - 1));
    assign result      = is_div_q ? x_n : acc_n;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (start && !div_by_zero) begin
            busy_q   <= 1'b1;
            is_div_q <= is_div;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= a;
            y_q      <= b;
        end else if (busy_q) begin
            acc_q <= acc_n;
            x_q   <= x_n;
            y_q   <= y_n;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_mc_legv8.sv
// Multi-cycle LEGv8 ALU: AND/OR/ADD/XOR/LSL/LSR in one cycle, MUL/UDIV iteratively.
// Latency: 1 cycle (single-cycle ops, UDIV by zero), WIDTH+1 cycles (MUL/UDIV).
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module alu_mc_legv8
    import alu_mc_legv8_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic           clock,
    input  logic           reset_n,
    alu_mc_legv8_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_n;
    logic [2:0]       op;
    logic             accept;
    logic             iter_start;
    logic             it_busy, it_done, it_dbz;
    logic [WIDTH-1:0] it_result;

    logic [WIDTH-1:0] as_v, bs_v, sum, f_sc;
    logic             carry, c_sc, v_sc;
    logic [WIDTH-1:0] f_q;
    logic [3:0]       status_q;

    assign op = fs_op(bus.FS);

    alu_mc_legv8_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (iter_start),
        .is_div      (op == OP_UDIV),
        .a           (bus.A),
        .b           (bus.B),
        .busy        (it_busy),
        .done        (it_done),
        .div_by_zero (it_dbz),
        .result      (it_result)
    );

    // Single-cycle datapath, evaluated on the raw inputs and captured on the accept edge
    always_comb begin
        as_v         = bus.FS[FS_INV_A] ? ~bus.A : bus.A;
        bs_v         = bus.FS[FS_INV_B] ? ~bus.B : bus.B;
        {carry, sum} = {1'b0, as_v} + {1'b0, bs_v} + {{WIDTH{1'b0}}, bus.C0};
        f_sc         = '0;
        c_sc         = 1'b0;
        v_sc         = 1'b0;
        case (op)
            OP_AND:  f_sc = as_v & bs_v;
            OP_OR:   f_sc = as_v | bs_v;
            OP_ADD: begin
                f_sc = sum;
                c_sc = carry;
                v_sc = ~(as_v[WIDTH-1] ^ bs_v[WIDTH-1]) & (sum[WIDTH-1] ^ as_v[WIDTH-1]);
            end
            OP_XOR:  f_sc = as_v ^ bs_v;
            OP_LSL:  f_sc = bus.A << bus.B[SHW-1:0];
            OP_LSR:  f_sc = bus.A >> bus.B[SHW-1:0];
            OP_UDIV: begin
                // only reaches the output when the divisor is zero
                f_sc = '1;
                v_sc = 1'b1;
            end
            default: f_sc = '0;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        accept     = 1'b0;
        iter_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (op == OP_MUL || (op == OP_UDIV && !it_dbz)) begin
                        iter_start = 1'b1;
                        state_n    = ST_EXEC;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                if (it_busy && it_done) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            f_q      <= '0;
            status_q <= '0;
        end else if (accept && state_n == ST_DONE) begin
            f_q      <= f_sc;
            status_q <= {v_sc, c_sc, f_sc[WIDTH-1], f_sc == '0};
        end else if (state_q == ST_EXEC && it_done) begin
            f_q      <= it_result;
            status_q <= {2'b00, it_result[WIDTH-1], it_result == '0};
        end
    end

    assign bus.in_ready  = reset_n && (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.F         = f_q;
    assign bus.status    = status_q;
endmodule

// File: tb/tb_alu_mc_legv8.sv
// Bench for alu_mc_legv8 (WIDTH=64): vector table through a scoreboard queue,
// plus hand sequences for back-pressure and reset during an iterative op.
module tb_alu_mc_legv8;
    import alu_mc_legv8_pkg::*;

    localparam int W = 64;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    alu_mc_legv8_if #(.WIDTH(W)) bus ();

    alu_mc_legv8 #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]   fs;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c0;
        logic [W-1:0] f;
        logic [3:0]   st;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [1:0] inv, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic c0, input logic [W-1:0] f,
                                input logic [3:0] st, input int lat);
        vec_t v;
        v.fs = {op, inv}; v.a = a; v.b = b; v.c0 = c0; v.f = f; v.st = st; v.lat = lat;
        return v;
    endfunction

    // Reference for iterative ops: plain unsigned arithmetic
    function automatic vec_t mk_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] f;
        f = (op == OP_MUL) ? a * b : a / b;
        return mk(op, 2'b00, a, b, 1'b0, f, {2'b00, f[W-1], f == '0}, W + 1);
    endfunction

    task automatic run_op(input vec_t v, input string name);
        vec_t exp;
        int   lat;
        @(negedge clock);
        bus.A = v.a; bus.B = v.b; bus.FS = v.fs; bus.C0 = v.c0; bus.in_valid = 1'b1;
        sb.push_back(v);
        lat = 0;
        while (!bus.in_ready && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check({name, "_in_ready"}, W'(bus.in_ready), W'(1));
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.A = {$urandom, $urandom};
        bus.B = {$urandom, $urandom};
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(negedge clock);
            lat++;
        end
        exp = sb.pop_front();
        check({name, "_F"}, bus.F, exp.f);
        check({name, "_status"}, W'(bus.status), W'(exp.st));
        check({name, "_latency"}, W'(lat), W'(exp.lat));
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check({name, "_idle_after_hs"}, W'({bus.in_ready, bus.out_valid}), W'(2'b10));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [W-1:0] ra, rb;
        logic [W-1:0] f_hold;
        logic [3:0]   s_hold;
        int           waited;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.FS = '0; bus.C0 = 1'b0;

        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", W'(bus.in_ready), W'(0));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_F", bus.F, '0);
        check("rst_status", W'(bus.status), W'(0));
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_release_in_ready", W'(bus.in_ready), W'(1));

        // {op, inv, A, B, C0, F, {V,C,N,Z}, latency}
        vecs.push_back(mk(OP_ADD, 2'b00, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'd2, 4'b0100, 1));
        vecs.push_back(mk(OP_ADD, 2'b01, 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 1));
        vecs.push_back(mk(OP_ADD, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1010, 1));
        vecs.push_back(mk(OP_ADD, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101, 1));
        vecs.push_back(mk(OP_LSR, 2'b00, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 64'd1, 4'b0000, 1));
        vecs.push_back(mk(OP_LSL, 2'b00, 64'd1, 64'd67, 1'b0, 64'd8, 4'b0000, 1));
        vecs.push_back(mk(OP_LSL, 2'b11, 64'd3, 64'd4, 1'b1, 64'h30, 4'b0000, 1));
        vecs.push_back(mk(OP_AND, 2'b00, 64'hF0F0, 64'hFF00, 1'b0, 64'hF000, 4'b0000, 1));
        vecs.push_back(mk(OP_OR, 2'b10, 64'd0, 64'h1234, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 1));
        vecs.push_back(mk(OP_XOR, 2'b00, 64'h1234, 64'h1234, 1'b0, 64'd0, 4'b0001, 1));
        vecs.push_back(mk(OP_MUL, 2'b00, 64'h1_0000_0001, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 65));
        vecs.push_back(mk(OP_MUL, 2'b11, 64'd12345, 64'd678, 1'b1, 64'd8369910, 4'b0000, 65));
        vecs.push_back(mk(OP_UDIV, 2'b00, 64'd100, 64'd7, 1'b0, 64'd14, 4'b0000, 65));
        vecs.push_back(mk(OP_UDIV, 2'b00, 64'd9, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010, 1));
        vecs.push_back(mk(OP_UDIV, 2'b00, 64'd5, 64'd9, 1'b0, 64'd0, 4'b0001, 65));
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            vecs.push_back(mk_model(OP_MUL, ra, rb));
            rb = rb >> $urandom_range(0, 60);
            if (rb == '0) rb = 64'd1;
            vecs.push_back(mk_model(OP_UDIV, ra, rb));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: result must hold while out_ready stays low; new beats ignored
        @(negedge clock);
        bus.A = 64'd10; bus.B = 64'd20; bus.FS = {OP_ADD, 2'b00}; bus.C0 = 1'b0; bus.in_valid = 1'b1;
        sb.push_back(mk(OP_ADD, 2'b00, 64'd10, 64'd20, 1'b0, 64'd30, 4'b0000, 1));
        @(posedge clock);
        @(negedge clock);
        bus.A = 64'd999; bus.B = 64'd1;
        waited = 0;
        while (!bus.out_valid && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        v = sb.pop_front();
        check("bp_F", bus.F, v.f);
        check("bp_status", W'(bus.status), W'(v.st));
        f_hold = v.f;
        s_hold = v.st;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check($sformatf("bp_hold%0d_F", c), bus.F, f_hold);
            check($sformatf("bp_hold%0d_ctl", c),
                  W'({bus.in_ready, bus.out_valid, bus.status}), W'({2'b01, s_hold}));
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("bp_release", W'({bus.in_ready, bus.out_valid}), W'(2'b10));

        // Reset in cycle 20 of a MUL: op must be discarded
        @(negedge clock);
        bus.A = 64'h1_0000_0001; bus.B = 64'hFFFF_FFFF; bus.FS = {OP_MUL, 2'b00}; bus.in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (19) @(negedge clock);
        check("mid_mul_busy", W'({bus.in_ready, bus.out_valid}), W'(2'b00));
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_rst_out_valid", W'(bus.out_valid), W'(0));
        check("mid_rst_F", bus.F, '0);
        check("mid_rst_in_ready", W'(bus.in_ready), W'(0));
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_release", W'({bus.in_ready, bus.out_valid}), W'(2'b10));
        waited = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clock);
            if (bus.out_valid) waited++;
        end
        check("mid_rst_discarded", W'(waited), W'(0));
        run_op(mk(OP_ADD, 2'b00, 64'd1, 64'd1, 1'b0, 64'd2, 4'b0000, 1), "post_rst_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
